dl_fifo: RTL and testbench

DL_FIFO -- requirements
Module: dl_fifo

---
 rtl/dl_fifo_mem.sv | 30 +++
 rtl/dl_fifo.sv | 87 ++++++++
 tb/tb_dl_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dl_fifo_mem.sv
// Storage array for dl_fifo: one synchronous write port, one combinational read port.
// Contents are deliberately left unreset; occupancy tracking lives in the control logic.
`ifndef DL_FIFO_MEM_SV
`define DL_FIFO_MEM_SV

module dl_fifo_mem #(
    parameter int NUM_BITS = 32,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NUM_BITS-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [NUM_BITS-1:0]        rd_data
);

    logic [NUM_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

`endif

// File: rtl/dl_fifo.sv
// First-word-fall-through FIFO with valid/ready handshakes on both sides.
// Pointer and occupancy control lives here; storage is delegated to dl_fifo_mem.
`ifndef DL_FIFO_SV
`define DL_FIFO_SV

module dl_fifo #(
    parameter int NUM_BITS = 32,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [NUM_BITS-1:0]        enq_data,
    output logic                       deq_val,
    input  logic                       deq_rdy,
    output logic [NUM_BITS-1:0]        deq_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq_fire;
    logic             deq_fire;

    // Status flags come only from registered occupancy, so the handshakes never
    // combinationally depend on the opposite side's input.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign enq_rdy = ~full;
    assign deq_val = ~empty;

    assign enq_fire = enq_val & enq_rdy;
    assign deq_fire = deq_val & deq_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (enq_fire && !deq_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq_fire && !enq_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Writes are suppressed during reset so a discarded word never lands in storage.
    dl_fifo_mem #(
        .NUM_BITS (NUM_BITS),
        .DEPTH    (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (enq_fire & ~rst),
        .wr_addr (wr_ptr_q),
        .wr_data (enq_data),
        .rd_addr (rd_ptr_q),
        .rd_data (deq_data)
    );

endmodule

`endif

// File: tb/tb_dl_fifo.sv
// Self-checking bench for dl_fifo: vector table for fill/drain plus hand-written
// sequences for streaming, full-side contention and reset during traffic.
module tb_dl_fifo;

    localparam int NUM_BITS = 32;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    typedef struct {
        bit                  rst;
        bit                  enqVal;
        logic [NUM_BITS-1:0] data;
        bit                  deqRdy;
        int                  expCount;
        bit                  expFull;
        bit                  expEmpty;
    } vector_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                enqVal;
    logic                enqRdy;
    logic [NUM_BITS-1:0] enqData;
    logic                deqVal;
    logic                deqRdy;
    logic [NUM_BITS-1:0] deqData;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;

    int                  numChecks  = 0;
    int                  numFails   = 0;
    int                  modelCount = 0;
    bit                  resetDone  = 0;
    logic [NUM_BITS-1:0] expQ[$];
    vector_t             vectors[$];

    always #5 clk = ~clk;

    dl_fifo #(
        .NUM_BITS (NUM_BITS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enq_val  (enqVal),
        .enq_rdy  (enqRdy),
        .enq_data (enqData),
        .deq_val  (deqVal),
        .deq_rdy  (deqRdy),
        .deq_data (deqData),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    task automatic check(input string name, input logic [NUM_BITS-1:0] actual,
                         input logic [NUM_BITS-1:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input int expCount, input bit expFull, input bit expEmpty);
        check("count", NUM_BITS'(count), NUM_BITS'(expCount));
        check("full", NUM_BITS'(full), NUM_BITS'(expFull));
        check("empty", NUM_BITS'(empty), NUM_BITS'(expEmpty));
    endtask

    // Drives one cycle, checks handshakes and dequeued data against the
    // scoreboard before the edge, then advances the model after the edge.
    task automatic applyStimulus(input bit r, input bit ev, input logic [NUM_BITS-1:0] d,
                                 input bit dr);
        bit enqFire;
        bit deqFire;
        rst     = r;
        enqVal  = ev;
        enqData = d;
        deqRdy  = dr;
        #1;
        enqFire = ev && (modelCount < DEPTH);
        deqFire = dr && (modelCount > 0);
        if (resetDone) begin
            check("enq_rdy", NUM_BITS'(enqRdy), NUM_BITS'(modelCount < DEPTH));
            check("deq_val", NUM_BITS'(deqVal), NUM_BITS'(modelCount > 0));
            if (deqFire) begin
                if (expQ.size() == 0) begin
                    numChecks++;
                    numFails++;
                    $display("[TB] FAIL scoreboard: dequeue with no expected word, got 0x%0h", deqData);
                end else begin
                    check("deq_data", deqData, expQ.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            expQ.delete();
            modelCount = 0;
            resetDone  = 1;
        end else begin
            if (enqFire) expQ.push_back(d);
            modelCount += int'(enqFire) - int'(deqFire);
        end
    endtask

    task automatic modelStep(input bit r, input bit ev, input logic [NUM_BITS-1:0] d,
                             input bit dr);
        applyStimulus(r, ev, d, dr);
        checkOutput(modelCount, modelCount == DEPTH, modelCount == 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        enqVal  = 1'b0;
        enqData = '0;
        deqRdy  = 1'b0;
        @(negedge clk);

        // Reset/idle, fill to full with a rejected fifth word, drain, empty dequeue.
        vectors.push_back('{1, 0, 32'h0,  0, 0, 0, 1});
        vectors.push_back('{0, 0, 32'h0,  0, 0, 0, 1});
        vectors.push_back('{0, 1, 32'hA0, 0, 1, 0, 0});
        vectors.push_back('{0, 1, 32'hA1, 0, 2, 0, 0});
        vectors.push_back('{0, 1, 32'hA2, 0, 3, 0, 0});
        vectors.push_back('{0, 1, 32'hA3, 0, 4, 1, 0});
        vectors.push_back('{0, 1, 32'hA4, 0, 4, 1, 0});
        vectors.push_back('{0, 0, 32'h0,  1, 3, 0, 0});
        vectors.push_back('{0, 0, 32'h0,  1, 2, 0, 0});
        vectors.push_back('{0, 0, 32'h0,  1, 1, 0, 0});
        vectors.push_back('{0, 0, 32'h0,  1, 0, 0, 1});
        vectors.push_back('{0, 0, 32'h0,  1, 0, 0, 1});

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].rst, vectors[i].enqVal, vectors[i].data, vectors[i].deqRdy);
            checkOutput(vectors[i].expCount, vectors[i].expFull, vectors[i].expEmpty);
        end

        // Streaming at count=2: occupancy holds while pointers wrap repeatedly.
        modelStep(0, 1, 32'hB0, 0);
        modelStep(0, 1, 32'hB1, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 32'hB2 + i, 1);
            checkOutput(2, 0, 0);
        end

        // Full with both sides active: only the dequeue fires, then the word enters.
        modelStep(0, 1, 32'hC1, 0);
        modelStep(0, 1, 32'hC2, 0);
        checkOutput(4, 1, 0);
        applyStimulus(0, 1, 32'hC3, 1);
        checkOutput(3, 0, 0);
        applyStimulus(0, 1, 32'hC3, 0);
        checkOutput(4, 1, 0);
        for (int i = 0; i < 4; i++) modelStep(0, 0, 32'h0, 1);

        // Reset during two-sided traffic discards everything in flight.
        modelStep(0, 1, 32'hD0, 0);
        modelStep(0, 1, 32'hD1, 0);
        modelStep(0, 1, 32'hD2, 0);
        applyStimulus(1, 1, 32'hD3, 1);
        checkOutput(0, 0, 1);
        modelStep(0, 1, 32'h55, 0);
        modelStep(0, 0, 32'h0, 1);
        modelStep(0, 0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
